// File: rtl/fpmul_arbiter_if.sv
// Bus between the arbiter, its two operand requesters and the shared multiplier core.
// slave is the arbiter's view; master is whoever drives requests and plays the core.
interface fpmul_arbiter_if #(
    parameter int SIZE = 32
);
    logic [1:0]      req;
    logic [SIZE-1:0] op1_a;
    logic [SIZE-1:0] op2_a;
    logic [SIZE-1:0] op1_b;
    logic [SIZE-1:0] op2_b;
    logic [1:0]      ack;
    logic [SIZE-1:0] res;
    logic [1:0]      res_rdy;
    logic            err;
    logic [SIZE-1:0] mul_op1;
    logic [SIZE-1:0] mul_op2;
    logic            mul_start;
    logic            mul_abort;
    logic [SIZE-1:0] mul_res;
    logic            mul_done;

    modport slave (
        input  req, op1_a, op2_a, op1_b, op2_b, mul_res, mul_done,
        output ack, res, res_rdy, err, mul_op1, mul_op2, mul_start, mul_abort
    );

    modport master (
        output req, op1_a, op2_a, op1_b, op2_b, mul_res, mul_done,
        input  ack, res, res_rdy, err, mul_op1, mul_op2, mul_start, mul_abort
    );
endinterface

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one variable-latency FP multiplier between requesters A and B,
// with a timeout that aborts the core and returns a quiet NaN flagged by err.
module fpmul_arbiter #(
    parameter int              SIZE    = 32,
    parameter int              TIMEOUT = 16,
    parameter logic [SIZE-1:0] NAN_VAL = 32'h7FC00000
) (
    input  logic                 clk,
    input  logic                 rst,
    fpmul_arbiter_if.slave       bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic            prio_q, prio_d;
    logic            owner_q, owner_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] res_q, res_d;
    logic [SIZE-1:0] op1_q, op1_d;
    logic [SIZE-1:0] op2_q, op2_d;
    logic            abort;
    logic            sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        abort   = 1'b0;
        sel     = (bus.req == 2'b11) ? prio_q : bus.req[1];
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    owner_d = sel;
                    op1_d   = sel ? bus.op1_b : bus.op1_a;
                    op2_d   = sel ? bus.op2_b : bus.op2_a;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving on the last allowed cycle still wins over the abort.
                if (bus.mul_done) begin
                    res_d   = bus.mul_res;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    res_d   = NAN_VAL;
                    err_d   = 1'b1;
                    abort   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                prio_d  = ~owner_q;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ack       = (state_q == ISSUE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        bus.res_rdy   = (state_q == RESP)  ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        bus.mul_start = (state_q == ISSUE);
        bus.mul_abort = abort;
        bus.err       = err_q;
        bus.res       = res_q;
        bus.mul_op1   = op1_q;
        bus.mul_op2   = op2_q;
    end
endmodule

// File: doc/fpmul_arbiter.md
Name: fpmul_arbiter

Overview:
- Shares one IEEE754 single-precision multiplier core between two requesters, A (index 0) and B (index 1).
- Accepts operand pairs, grants with a round-robin policy, launches the core, and waits for its variable-latency done.
- Routes the result back to the owning requester with a one-hot res_rdy, in the same style as the top level's res_rdy[1:0].
- Sits between the user-side operand sources and the multiplier core inside the top level.

Parameters:
- SIZE, 32, operand/result width in bits.
- TIMEOUT, 16, maximum WAIT cycles before the operation is aborted.
- NAN_VAL, 32'h7FC00000, result returned on timeout (quiet NaN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  request per requester; held with operands until the matching ack.
- op1_a  in  SIZE  requester A operand 1.
- op2_a  in  SIZE  requester A operand 2.
- op1_b  in  SIZE  requester B operand 1.
- op2_b  in  SIZE  requester B operand 2.
- ack  out  2  one-cycle one-hot pulse: operands of that requester accepted.
- res  out  SIZE  result; valid when res_rdy != 0; holds its value otherwise.
- res_rdy  out  2  one-cycle one-hot pulse: res belongs to that requester.
- err  out  1  high together with res_rdy when res is NAN_VAL due to timeout.
- mul_op1  out  SIZE  core operand 1, registered.
- mul_op2  out  SIZE  core operand 2, registered.
- mul_start  out  1  one-cycle launch pulse to the core.
- mul_abort  out  1  one-cycle cancel pulse to the core on timeout.
- mul_res  in  SIZE  core result.
- mul_done  in  1  core result valid, one cycle.

Behaviour:
- Reset values (synchronous, active-high, wins over everything):
  - state=IDLE, prio=0 (A preferred).
  - ack, res_rdy, err, mul_start, mul_abort = 0.
  - res, mul_op1, mul_op2 = 0; timeout counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample req. If only one bit is set, owner = that requester.
  - If both are set, owner = prio.
  - Latch the owner's operands into mul_op1/mul_op2 and go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - ack[owner]=1 and mul_start=1 for this cycle.
  - Clear the counter; go to WAIT.
  - The requester must deassert or change req after seeing ack. req is sampled only in IDLE.
- WAIT:
  - mul_done sampled only here. If mul_done=1: res <= mul_res, err <= 0, go to RESP.
  - Otherwise counter++. When the counter reaches TIMEOUT-1 without done:
    - res <= NAN_VAL, err <= 1, mul_abort=1 for one cycle, go to RESP.
  - mul_done on the timeout cycle takes precedence: normal result, no abort.
- RESP (exactly 1 cycle):
  - res_rdy[owner]=1; err is valid this cycle.
  - prio <= ~owner; go to IDLE.
  - err returns to 0 the next cycle. res holds until the next RESP.
- Timing and throughput:
  - Minimum occupancy is 4 cycles per operation plus the core latency minus 1.
  - The core must not assert done in the same cycle as mul_start.
- Latency: req high at IDLE edge t → ack at t+1 → res_rdy at t+1+L+1, where L ≥ 1 is the core latency in cycles after start.
- mul_done outside WAIT is ignored, including stale done after an abort or after reset.
- Fairness: with both requesters continuously requesting, grants strictly alternate A,B,A,B.
- Reset mid-operation: immediate return to IDLE. No ack or res_rdy is emitted for the in-flight operation. The core shares rst.
- Counter width is clog2(TIMEOUT+1). No wrap is possible because the counter is cleared in ISSUE.

Test Plan:
- Single A request, op1_a=0x3FC00000, op2_a=0x40000000, core latency 3 → ack=01 one cycle; res_rdy=01 with res=0x40400000, err=0; ack to res_rdy spacing exactly 4 cycles.
- req=11 asserted together after reset → A is granted first (ack=01). B is granted on the next IDLE (ack=10). res_rdy order is 01 then 10.
- Both requesters held high for 6 operations → ack sequence 01,10,01,10,01,10; every res_rdy matches its preceding ack.
- Core never asserts done, TIMEOUT=16 → mul_abort pulses once after 16 WAIT cycles; next cycle res_rdy=owner, res=0x7FC00000, err=1. A stale mul_done 2 cycles later is ignored.
- rst=1 during WAIT → next cycle all outputs 0, state IDLE, prio=0, no res_rdy emitted. A new B request then completes normally.
- mul_done pulse injected while in IDLE and while in ISSUE → no res_rdy and no change to res.
